bus_reg_writer: RTL and testbench
=================================

# bus_reg_writer

Destination-side counterpart of the 32-way register bus multiplexer. It takes a value driven on the 32-bit bus plus a 5-bit destination select. It queues the write in a 2-entry FIFO and commits it into a bank of 32 × 32-bit registers. The flattened register contents feed the bus multiplexer's r0–r31 inputs, closing the loop between bus source and bus destination.

## Interface

Parameters:
- WIDTH, 32, register and bus data width
- DEPTH, 2, write-queue entries (fixed at 2 for this revision)
- R0_ZERO, 1, when 1 register 0 is hardwired to zero and writes to it are discarded

Ports:
- clk  in  1  single clock; all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- wr_valid  in  1  a write request is present on wr_sel/wr_data
- wr_ready  out  1  queue can accept a request this cycle
- wr_sel  in  5  destination register index 0–31
- wr_data  in  WIDTH  bus value to write
- hold  in  1  stalls commits (bank being read/sampled); does not block accepts
- regs_out  out  32×WIDTH  register i on bits [WIDTH·i+WIDTH−1 : WIDTH·i]
- commit_valid  out  1  one-cycle pulse: a write was committed on the previous edge
- commit_sel  out  5  index of the committed write, valid with commit_valid
- pending  out  2  current queue occupancy 0–2
- write_count  out  16  total committed writes, saturating

## Operation

- Accept: wr_valid && wr_ready at an edge pushes {wr_sel, wr_data} to the FIFO tail.
- wr_ready = !clear && (pending < 2). It is derived from registered occupancy only. It does not look ahead to a same-cycle drain, so a full queue never accepts, even when a drain happens in that cycle.
- Drain: at an edge with pending > 0 and hold = 0, the head entry is written to its register and popped. At most one commit per cycle, in strict FIFO order.
- Occupancy FSM has three states: EMPTY (0), ONE (1), FULL (2).
  - EMPTY: accept → ONE.
  - ONE: accept with no drain → FULL; drain with no accept → EMPTY; accept and drain together → ONE.
  - FULL: drain → ONE; hold → FULL.
- Simultaneous accept and drain in ONE: the old head commits and the new entry becomes the head. The new entry is never committed in the same cycle it is accepted.
- R0_ZERO = 1 with a write to index 0: the register stays 0. The write still counts as a commit: commit_valid pulses, commit_sel = 0, and write_count increments.
- Commit outputs:
  - commit_valid and commit_sel are registered and asserted in the cycle after the edge that wrote the register.
  - commit_valid is 0 in any cycle following an edge without a commit.
  - commit_sel holds its last value when commit_valid is 0.
- write_count increments by 1 per commit and saturates at 16'hFFFF (no wrap).
- Back-to-back writes to the same index commit in order; the last one wins.
- clear mid-operation: queued entries are discarded and never committed, including an entry accepted the same cycle.

## Timing

- Reset values (edge with clear = 1):
  - every register, regs_out, pending, write_count, commit_sel = 0; commit_valid = 0.
  - wr_ready = 0 while clear is high and 1 in the first cycle after.
- Latency from an accept at edge N with an empty queue and hold = 0:
  - register written at edge N+1;
  - regs_out shows the new value after edge N+1;
  - commit_valid is high in the cycle after edge N+1.
- Each cycle that hold is high while the entry is queued adds one cycle of latency.
- Sustained throughput is 1 write/cycle with hold low: wr_ready stays high because occupancy remains at 1 during streaming.
- regs_out is driven directly from the register flops; it is never combinationally bypassed from the queue.

## Test plan

- Single writes (clear, then accept sel=1/data=1, sel=7/data=400, sel=19/data=64000, one per cycle, hold=0) → regs 1, 7, 19 read 1, 400, 64000. commit_sel pulses 1, 7, 19 on consecutive cycles. write_count = 3. All other regs are 0.
- Fill under hold (hold=1; offer sel=3/data=5, sel=4/data=6, sel=5/data=7 on consecutive cycles) →
  - first two accepted, pending = 2, wr_ready = 0, third held;
  - drop hold → reg3=5, then reg4=6, then the third is accepted and reg5=7;
  - no register changes while hold=1.
- Simultaneous accept/drain (pending=1, head sel=2/data=10; accept sel=2/data=20 that cycle) → pending stays 1. reg2=10 after that edge and 20 one edge later.
- R0 hardwired (R0_ZERO=1; write sel=0/data=32'hDEADBEEF) → reg0 stays 0, commit_valid pulses with commit_sel=0, write_count increments.
- Clear mid-operation (pending=2 with sel=8/9 queued, assert clear for one cycle) → pending=0, reg8 = reg9 = 0, no commit_valid pulse, write_count=0, wr_ready=1 on the next cycle.
- Saturation (preload by 65 535 commits, then 2 more) → write_count holds at 16'hFFFF.

Source files
------------

// File: rtl/bus_reg_writer.sv
// Bus destination: queues {sel, data} writes in a 2-entry FIFO and commits them
// one per cycle into a 32 x WIDTH register bank exposed as a flat vector.
module bus_reg_writer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4:0]            wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  hold,
    output logic [32*WIDTH-1:0]   regs_out,
    output logic                  commit_valid,
    output logic [4:0]            commit_sel,
    output logic [1:0]            pending,
    output logic [15:0]           write_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [4:0]         head_sel_p0;
    logic [WIDTH-1:0]   head_data_p0;
    logic [4:0]         tail_sel_p0;
    logic [WIDTH-1:0]   tail_data_p0;
    logic [WIDTH-1:0]   bank [32];

    logic accept;
    logic drain;
    logic r0_discard;

    assign pending    = state;
    // Ready looks only at registered occupancy; a full queue never accepts.
    assign wr_ready   = !clear && (32'(pending) < DEPTH);
    assign accept     = wr_valid && wr_ready;
    assign drain      = (state != EMPTY) && !hold;
    assign r0_discard = (R0_ZERO != 0) && (head_sel_p0 == 5'd0);

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= EMPTY;
            commit_valid <= 1'b0;
            commit_sel   <= 5'd0;
            write_count  <= 16'd0;
            for (int i = 0; i < 32; i++) begin
                bank[i] <= '0;
            end
        end else begin
            commit_valid <= drain;
            if (drain) begin
                commit_sel <= head_sel_p0;
                if (!r0_discard) begin
                    bank[head_sel_p0] <= head_data_p0;
                end
                if (write_count != 16'hFFFF) begin
                    write_count <= write_count + 16'd1;
                end
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_sel_p0  <= wr_sel;
                        head_data_p0 <= wr_data;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    // With a same-cycle drain the new entry replaces the committed head.
                    if (accept && drain) begin
                        head_sel_p0  <= wr_sel;
                        head_data_p0 <= wr_data;
                    end else if (accept) begin
                        tail_sel_p0  <= wr_sel;
                        tail_data_p0 <= wr_data;
                        state        <= FULL;
                    end else if (drain) begin
                        state        <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        head_sel_p0  <= tail_sel_p0;
                        head_data_p0 <= tail_data_p0;
                        state        <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_flat
        assign regs_out[WIDTH*g +: WIDTH] = bank[g];
    end

endmodule

// File: tb/tb_bus_reg_writer.sv
// Directed-vector bench for bus_reg_writer with hand-computed expectations.
module tb_bus_reg_writer;

    localparam int WIDTH = 32;

    logic                 clk = 1'b0;
    logic                 clear;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [4:0]           wr_sel;
    logic [WIDTH-1:0]     wr_data;
    logic                 hold;
    logic [32*WIDTH-1:0]  regs_out;
    logic                 commit_valid;
    logic [4:0]           commit_sel;
    logic [1:0]           pending;
    logic [15:0]          write_count;

    int n_tests = 0;
    int n_fail  = 0;

    bus_reg_writer #(.WIDTH(WIDTH), .DEPTH(2), .R0_ZERO(1)) dut (
        .clk          (clk),
        .clear        (clear),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .hold         (hold),
        .regs_out     (regs_out),
        .commit_valid (commit_valid),
        .commit_sel   (commit_sel),
        .pending      (pending),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int idx);
        return regs_out[WIDTH*idx +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s, input logic [31:0] d);
        wr_valid = v;
        wr_sel   = s;
        wr_data  = d;
    endtask

    initial begin
        clear = 1'b1;
        hold  = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        check("rst_ready",   {31'd0, wr_ready}, 32'd0);
        check("rst_pending", {30'd0, pending}, 32'd0);
        check("rst_count",   {16'd0, write_count}, 32'd0);
        check("rst_cvalid",  {31'd0, commit_valid}, 32'd0);
        check("rst_csel",    {27'd0, commit_sel}, 32'd0);
        check("rst_reg5",    rd(5), 32'd0);
        clear = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, wr_ready}, 32'd1);

        // Single writes, one per cycle
        drive(1'b1, 5'd1, 32'd1);
        tick();
        check("s_pend1", {30'd0, pending}, 32'd1);
        check("s_reg1_early", rd(1), 32'd0);
        drive(1'b1, 5'd7, 32'd400);
        tick();
        check("s_reg1", rd(1), 32'd1);
        check("s_cv1",  {31'd0, commit_valid}, 32'd1);
        check("s_cs1",  {27'd0, commit_sel}, 32'd1);
        drive(1'b1, 5'd19, 32'd64000);
        tick();
        check("s_reg7", rd(7), 32'd400);
        check("s_cs7",  {27'd0, commit_sel}, 32'd7);
        check("s_ready_stream", {31'd0, wr_ready}, 32'd1);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        check("s_reg19", rd(19), 32'd64000);
        check("s_cs19",  {27'd0, commit_sel}, 32'd19);
        check("s_pend0", {30'd0, pending}, 32'd0);
        tick();
        check("s_cv_low",   {31'd0, commit_valid}, 32'd0);
        check("s_cs_hold",  {27'd0, commit_sel}, 32'd19);
        check("s_count",    {16'd0, write_count}, 32'd3);
        check("s_reg2",     rd(2), 32'd0);
        check("s_reg0",     rd(0), 32'd0);

        // Fill under hold
        hold = 1'b1;
        drive(1'b1, 5'd3, 32'd5);
        tick();
        drive(1'b1, 5'd4, 32'd6);
        tick();
        check("h_pend2",  {30'd0, pending}, 32'd2);
        check("h_ready0", {31'd0, wr_ready}, 32'd0);
        drive(1'b1, 5'd5, 32'd7);
        tick();
        check("h_pend_stay", {30'd0, pending}, 32'd2);
        check("h_reg3_hold", rd(3), 32'd0);
        check("h_cv_hold",   {31'd0, commit_valid}, 32'd0);
        hold = 1'b0;
        tick();
        check("h_reg3",  rd(3), 32'd5);
        check("h_reg4_early", rd(4), 32'd0);
        check("h_pend1", {30'd0, pending}, 32'd1);
        tick();
        check("h_reg4",  rd(4), 32'd6);
        check("h_reg5_early", rd(5), 32'd0);
        check("h_pend_acc", {30'd0, pending}, 32'd1);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        check("h_reg5",  rd(5), 32'd7);
        check("h_pend0", {30'd0, pending}, 32'd0);

        // Simultaneous accept and drain in ONE
        drive(1'b1, 5'd2, 32'd10);
        tick();
        drive(1'b1, 5'd2, 32'd20);
        tick();
        check("sim_pend1", {30'd0, pending}, 32'd1);
        check("sim_reg2a", rd(2), 32'd10);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        check("sim_reg2b", rd(2), 32'd20);
        check("sim_count", {16'd0, write_count}, 32'd8);

        // Register 0 hardwired
        drive(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        tick();
        check("r0_reg0",  rd(0), 32'd0);
        check("r0_cv",    {31'd0, commit_valid}, 32'd1);
        check("r0_cs",    {27'd0, commit_sel}, 32'd0);
        check("r0_count", {16'd0, write_count}, 32'd9);

        // Clear mid-operation
        hold = 1'b1;
        drive(1'b1, 5'd8, 32'd11);
        tick();
        drive(1'b1, 5'd9, 32'd12);
        tick();
        check("c_pend2", {30'd0, pending}, 32'd2);
        clear = 1'b1;
        hold  = 1'b0;
        tick();
        check("c_pend0", {30'd0, pending}, 32'd0);
        check("c_count", {16'd0, write_count}, 32'd0);
        check("c_cv",    {31'd0, commit_valid}, 32'd0);
        clear = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        #1;
        check("c_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        check("c_cv_after", {31'd0, commit_valid}, 32'd0);
        check("c_reg8", rd(8), 32'd0);
        check("c_reg9", rd(9), 32'd0);
        check("c_reg7", rd(7), 32'd0);

        // Saturation: 65535 streaming edges commit 65534 writes
        drive(1'b1, 5'd10, 32'd0);
        for (int i = 0; i < 65535; i++) begin
            wr_data = i;
            tick();
        end
        check("sat_fffe",  {16'd0, write_count}, 32'h0000FFFE);
        check("sat_ready", {31'd0, wr_ready}, 32'd1);
        tick();
        tick();
        check("sat_ffff", {16'd0, write_count}, 32'h0000FFFF);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        check("sat_hold", {16'd0, write_count}, 32'h0000FFFF);
        check("sat_pend", {30'd0, pending}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
